multicycle_control_fsm: RTL and testbench

Multi-cycle control unit for the RV32I core that replaces the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with the instruction and data memories. It holds the decoded control fields in registers across the instruction. It adds a configurable memory-wait timeout and a trap path for illegal opcodes, optional FENCE/SYSTEM, and stalled memories.

---
 rtl/multicycle_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// registered decode fields, memory handshakes, wait timeout and trap handling.
module multicycle_control_fsm #(
  parameter bit EN_FENCE_SYS = 1'b1,
  parameter int MEM_TIMEOUT  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       trap_clear,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch_op,
  output logic       memRead,
  output logic       memtoReg,
  output logic       memWrite,
  output logic       regWriteEn,
  output logic       operand_B_sel,
  output logic [1:0] next_PC_sel,
  output logic [1:0] operand_A_sel,
  output logic [1:0] extend_sel,
  output logic [2:0] ALUOp,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction class decides the path taken out of EXEC.
  localparam logic [1:0] KIND_WB    = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_SHORT = 2'd3;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]    state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    trap_cause_r, trap_cause_next;
  logic          timeout_hit;

  logic [2:0] dec_alu, alu_r;
  logic [1:0] dec_a, a_r, dec_ext, ext_r, dec_npc, npc_r, dec_kind, kind_r;
  logic       dec_b, b_r, dec_branch, branch_r, dec_m2r, m2r_r, dec_legal;

  always_comb begin
    dec_alu    = 3'b000;
    dec_a      = 2'b00;
    dec_b      = 1'b0;
    dec_ext    = 2'b00;
    dec_npc    = 2'b00;
    dec_branch = 1'b0;
    dec_m2r    = 1'b0;
    dec_kind   = KIND_WB;
    dec_legal  = 1'b1;
    case (opcode)
      OP_R:      dec_alu = 3'b000;
      OP_I:      begin dec_alu = 3'b001; dec_b = 1'b1; end
      OP_LOAD:   begin dec_alu = 3'b100; dec_b = 1'b1; dec_m2r = 1'b1; dec_kind = KIND_LOAD; end
      OP_STORE:  begin dec_alu = 3'b101; dec_b = 1'b1; dec_ext = 2'b01; dec_kind = KIND_STORE; end
      OP_BRANCH: begin dec_alu = 3'b010; dec_npc = 2'b01; dec_branch = 1'b1; dec_kind = KIND_SHORT; end
      OP_JAL:    begin dec_alu = 3'b011; dec_a = 2'b10; dec_npc = 2'b10; end
      OP_JALR:   begin dec_alu = 3'b011; dec_a = 2'b10; dec_b = 1'b1; dec_npc = 2'b11; end
      OP_AUIPC:  begin dec_alu = 3'b110; dec_a = 2'b01; dec_b = 1'b1; dec_ext = 2'b10; end
      OP_LUI:    begin dec_alu = 3'b110; dec_a = 2'b11; dec_b = 1'b1; dec_ext = 2'b10; end
      OP_FENCE, OP_SYSTEM: begin dec_kind = KIND_SHORT; dec_legal = EN_FENCE_SYS; end
      default:   dec_legal = 1'b0;
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LIMIT);

  // An ack arriving on the limit cycle takes priority over the timeout.
  always_comb begin
    state_next      = state;
    trap_cause_next = trap_cause_r;
    case (state)
      ST_RST:    state_next = ST_FETCH;
      ST_FETCH:
        if (imem_ack) state_next = ST_DECODE;
        else if (timeout_hit) begin
          state_next      = ST_TRAP;
          trap_cause_next = 2'b10;
        end
      ST_DECODE:
        if (!dec_legal) begin
          state_next      = ST_TRAP;
          trap_cause_next = 2'b01;
        end else state_next = ST_EXEC;
      ST_EXEC:
        case (kind_r)
          KIND_LOAD, KIND_STORE: state_next = ST_MEM;
          KIND_SHORT:            state_next = ST_FETCH;
          default:               state_next = ST_WB;
        endcase
      ST_MEM:
        if (dmem_ack) state_next = (kind_r == KIND_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout_hit) begin
          state_next      = ST_TRAP;
          trap_cause_next = 2'b11;
        end
      ST_WB:     state_next = ST_FETCH;
      ST_TRAP:
        if (trap_clear) begin
          state_next      = ST_FETCH;
          trap_cause_next = 2'b00;
        end
      default:   state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RST;
      trap_cause_r <= 2'b00;
    end else begin
      state        <= state_next;
      trap_cause_r <= trap_cause_next;
    end
  end

  // Counter restarts whenever a state is entered, so FETCH and MEM each get a fresh budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (state == ST_FETCH || state == ST_MEM) wait_cnt <= wait_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_r    <= 3'b000;
      a_r      <= 2'b00;
      b_r      <= 1'b0;
      ext_r    <= 2'b00;
      npc_r    <= 2'b00;
      branch_r <= 1'b0;
      m2r_r    <= 1'b0;
      kind_r   <= KIND_WB;
    end else if (state == ST_DECODE) begin
      alu_r    <= dec_alu;
      a_r      <= dec_a;
      b_r      <= dec_b;
      ext_r    <= dec_ext;
      npc_r    <= dec_npc;
      branch_r <= dec_branch;
      m2r_r    <= dec_m2r;
      kind_r   <= dec_kind;
    end
  end

  assign imem_req      = (state == ST_FETCH);
  assign ir_write      = (state == ST_FETCH) && imem_ack;
  assign dmem_req      = (state == ST_MEM);
  assign memRead       = (state == ST_MEM) && (kind_r == KIND_LOAD);
  assign memWrite      = (state == ST_MEM) && (kind_r == KIND_STORE);
  assign regWriteEn    = (state == ST_WB);
  assign pc_write      = ((state == ST_EXEC) && (kind_r == KIND_SHORT)) ||
                         ((state == ST_MEM) && dmem_ack && (kind_r == KIND_STORE)) ||
                         (state == ST_WB);
  assign branch_op     = branch_r;
  assign memtoReg      = m2r_r;
  assign operand_B_sel = b_r;
  assign next_PC_sel   = npc_r;
  assign operand_A_sel = a_r;
  assign extend_sel    = ext_r;
  assign ALUOp         = alu_r;
  assign trap          = (state == ST_TRAP);
  assign trap_cause    = trap_cause_r;
  assign state_o       = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm with fence/system
// disabled and a 4-cycle memory wait limit.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b0101011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imem_ack, dmem_ack, trap_clear;
  logic       imem_req, dmem_req, ir_write, pc_write;
  logic       branch_op, memRead, memtoReg, memWrite, regWriteEn, operand_B_sel;
  logic [1:0] next_PC_sel, operand_A_sel, extend_sel;
  logic [2:0] ALUOp;
  logic       trap;
  logic [1:0] trap_cause;
  logic [2:0] state_o;

  int n_compared = 0;
  int n_failed   = 0;
  int pc_pulses  = 0;
  int rw_pulses  = 0;
  int pc0, rw0;

  logic [24:0] all_out;
  assign all_out = {imem_req, dmem_req, ir_write, pc_write, branch_op, memRead, memtoReg,
                    memWrite, regWriteEn, operand_B_sel, next_PC_sel, operand_A_sel,
                    extend_sel, ALUOp, trap, trap_cause, state_o};

  multicycle_control_fsm #(.EN_FENCE_SYS(1'b0), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .trap_clear(trap_clear), .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .branch_op(branch_op), .memRead(memRead), .memtoReg(memtoReg),
    .memWrite(memWrite), .regWriteEn(regWriteEn), .operand_B_sel(operand_B_sel),
    .next_PC_sel(next_PC_sel), .operand_A_sel(operand_A_sel), .extend_sel(extend_sel),
    .ALUOp(ALUOp), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pc_write)   pc_pulses <= pc_pulses + 1;
    if (regWriteEn) rw_pulses <= rw_pulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic iack, input logic dack, input logic tclr);
    opcode     = op;
    imem_ack   = iack;
    dmem_ack   = dack;
    trap_clear = tclr;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic snapCounts();
    pc0 = pc_pulses;
    rw0 = rw_pulses;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(7'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("reset_outputs", 32'(all_out), 32'd0);
    rst_n = 1'b1;

    // R-type with imem_ack held high
    nextCycle();
    applyStimulus(OP_R, 1'b1, 1'b0, 1'b0);
    snapCounts();
    checkOutput("r_fetch_state", 32'(state_o), 32'd1);
    checkOutput("r_fetch_ireq", 32'(imem_req), 32'd1);
    checkOutput("r_fetch_irw", 32'(ir_write), 32'd1);
    nextCycle();
    checkOutput("r_decode_state", 32'(state_o), 32'd2);
    checkOutput("r_decode_irw", 32'(ir_write), 32'd0);
    nextCycle();
    checkOutput("r_exec_state", 32'(state_o), 32'd3);
    checkOutput("r_exec_aluop", 32'(ALUOp), 32'd0);
    checkOutput("r_exec_rwe", 32'(regWriteEn), 32'd0);
    checkOutput("r_exec_pcw", 32'(pc_write), 32'd0);
    nextCycle();
    checkOutput("r_wb_state", 32'(state_o), 32'd5);
    checkOutput("r_wb_rwe", 32'(regWriteEn), 32'd1);
    checkOutput("r_wb_pcw", 32'(pc_write), 32'd1);
    nextCycle();
    checkOutput("r_back_fetch", 32'(state_o), 32'd1);
    checkOutput("r_pc_pulses", 32'(pc_pulses - pc0), 32'd1);
    checkOutput("r_rw_pulses", 32'(rw_pulses - rw0), 32'd1);

    // LOAD with dmem_ack arriving on the third MEM cycle
    applyStimulus(OP_LOAD, 1'b1, 1'b0, 1'b0);
    snapCounts();
    nextCycle();
    nextCycle();
    checkOutput("ld_exec_state", 32'(state_o), 32'd3);
    checkOutput("ld_aluop", 32'(ALUOp), 32'd4);
    checkOutput("ld_memtoreg", 32'(memtoReg), 32'd1);
    checkOutput("ld_extend", 32'(extend_sel), 32'd0);
    checkOutput("ld_bsel", 32'(operand_B_sel), 32'd1);
    checkOutput("ld_exec_memread", 32'(memRead), 32'd0);
    nextCycle();
    checkOutput("ld_mem1_state", 32'(state_o), 32'd4);
    checkOutput("ld_mem1_dreq", 32'(dmem_req), 32'd1);
    checkOutput("ld_mem1_memread", 32'(memRead), 32'd1);
    nextCycle();
    checkOutput("ld_mem2_state", 32'(state_o), 32'd4);
    nextCycle();
    applyStimulus(OP_LOAD, 1'b1, 1'b1, 1'b0);
    checkOutput("ld_mem3_state", 32'(state_o), 32'd4);
    checkOutput("ld_mem3_memread", 32'(memRead), 32'd1);
    checkOutput("ld_mem3_pcw", 32'(pc_write), 32'd0);
    nextCycle();
    applyStimulus(OP_LOAD, 1'b1, 1'b0, 1'b0);
    checkOutput("ld_wb_state", 32'(state_o), 32'd5);
    checkOutput("ld_wb_rwe", 32'(regWriteEn), 32'd1);
    checkOutput("ld_wb_memread", 32'(memRead), 32'd0);
    nextCycle();
    checkOutput("ld_back_fetch", 32'(state_o), 32'd1);
    checkOutput("ld_pc_pulses", 32'(pc_pulses - pc0), 32'd1);
    checkOutput("ld_rw_pulses", 32'(rw_pulses - rw0), 32'd1);

    // STORE with zero-wait acks
    applyStimulus(OP_STORE, 1'b1, 1'b1, 1'b0);
    snapCounts();
    nextCycle();
    nextCycle();
    checkOutput("st_exec_state", 32'(state_o), 32'd3);
    checkOutput("st_extend", 32'(extend_sel), 32'd1);
    checkOutput("st_aluop", 32'(ALUOp), 32'd5);
    nextCycle();
    checkOutput("st_mem_state", 32'(state_o), 32'd4);
    checkOutput("st_mem_memwrite", 32'(memWrite), 32'd1);
    checkOutput("st_mem_memread", 32'(memRead), 32'd0);
    checkOutput("st_mem_pcw", 32'(pc_write), 32'd1);
    nextCycle();
    checkOutput("st_back_fetch", 32'(state_o), 32'd1);
    checkOutput("st_memwrite_off", 32'(memWrite), 32'd0);
    checkOutput("st_pc_pulses", 32'(pc_pulses - pc0), 32'd1);
    checkOutput("st_rw_pulses", 32'(rw_pulses - rw0), 32'd0);

    // BRANCH: retires from EXEC
    applyStimulus(OP_BRANCH, 1'b1, 1'b1, 1'b0);
    snapCounts();
    nextCycle();
    nextCycle();
    checkOutput("br_exec_state", 32'(state_o), 32'd3);
    checkOutput("br_branch_op", 32'(branch_op), 32'd1);
    checkOutput("br_next_pc_sel", 32'(next_PC_sel), 32'd1);
    checkOutput("br_aluop", 32'(ALUOp), 32'd2);
    checkOutput("br_exec_pcw", 32'(pc_write), 32'd1);
    nextCycle();
    checkOutput("br_back_fetch", 32'(state_o), 32'd1);
    checkOutput("br_pc_pulses", 32'(pc_pulses - pc0), 32'd1);
    checkOutput("br_rw_pulses", 32'(rw_pulses - rw0), 32'd0);

    // Unknown opcode traps with cause 01
    applyStimulus(OP_BAD, 1'b1, 1'b0, 1'b0);
    snapCounts();
    nextCycle();
    checkOutput("bad_decode_state", 32'(state_o), 32'd2);
    nextCycle();
    checkOutput("bad_trap_state", 32'(state_o), 32'd6);
    checkOutput("bad_trap", 32'(trap), 32'd1);
    checkOutput("bad_cause", 32'(trap_cause), 32'd1);
    checkOutput("bad_trap_ireq", 32'(imem_req), 32'd0);
    nextCycle();
    checkOutput("bad_trap_held", 32'(state_o), 32'd6);
    applyStimulus(OP_BAD, 1'b1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(OP_SYSTEM, 1'b1, 1'b0, 1'b0);
    checkOutput("bad_clear_state", 32'(state_o), 32'd1);
    checkOutput("bad_clear_trap", 32'(trap), 32'd0);
    checkOutput("bad_clear_cause", 32'(trap_cause), 32'd0);
    checkOutput("bad_pc_pulses", 32'(pc_pulses - pc0), 32'd0);

    // SYSTEM is illegal when fence/system support is disabled
    nextCycle();
    nextCycle();
    checkOutput("sys_trap_state", 32'(state_o), 32'd6);
    checkOutput("sys_cause", 32'(trap_cause), 32'd1);
    applyStimulus(OP_SYSTEM, 1'b1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(OP_R, 1'b0, 1'b0, 1'b0);
    checkOutput("sys_clear_state", 32'(state_o), 32'd1);
    checkOutput("sys_clear_trap", 32'(trap), 32'd0);

    // Fetch timeout: no ack for 4 FETCH cycles
    snapCounts();
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("ito_fetch4_state", 32'(state_o), 32'd1);
    checkOutput("ito_fetch4_ireq", 32'(imem_req), 32'd1);
    nextCycle();
    checkOutput("ito_trap_state", 32'(state_o), 32'd6);
    checkOutput("ito_cause", 32'(trap_cause), 32'd2);
    checkOutput("ito_ireq_off", 32'(imem_req), 32'd0);
    applyStimulus(OP_R, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(OP_R, 1'b0, 1'b0, 1'b0);
    checkOutput("ito_clear_state", 32'(state_o), 32'd1);

    // Ack on the limit cycle wins over the timeout
    nextCycle();
    nextCycle();
    nextCycle();
    applyStimulus(OP_R, 1'b1, 1'b0, 1'b0);
    checkOutput("ack4_state", 32'(state_o), 32'd1);
    checkOutput("ack4_irw", 32'(ir_write), 32'd1);
    nextCycle();
    checkOutput("ack4_decode", 32'(state_o), 32'd2);
    checkOutput("ack4_no_trap", 32'(trap), 32'd0);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("ack4_retire_fetch", 32'(state_o), 32'd1);
    checkOutput("ito_pc_pulses", 32'(pc_pulses - pc0), 32'd1);

    // Reset asserted during MEM of a LOAD
    applyStimulus(OP_LOAD, 1'b1, 1'b0, 1'b0);
    snapCounts();
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("rst_pre_memread", 32'(memRead), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outputs", 32'(all_out), 32'd0);
    nextCycle();
    checkOutput("rst_low_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rst_release_state", 32'(state_o), 32'd1);
    checkOutput("rst_rw_pulses", 32'(rw_pulses - rw0), 32'd0);
    checkOutput("rst_pc_pulses", 32'(pc_pulses - pc0), 32'd0);

    // Data timeout: STORE whose dmem_ack never comes
    applyStimulus(OP_STORE, 1'b1, 1'b0, 1'b0);
    snapCounts();
    nextCycle();
    nextCycle();
    nextCycle();
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("dto_mem4_state", 32'(state_o), 32'd4);
    nextCycle();
    checkOutput("dto_trap_state", 32'(state_o), 32'd6);
    checkOutput("dto_cause", 32'(trap_cause), 32'd3);
    checkOutput("dto_dreq_off", 32'(dmem_req), 32'd0);
    checkOutput("dto_pc_pulses", 32'(pc_pulses - pc0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
